// File: rtl/key_debounce_pkg.sv
// Shared definitions for the push-button conditioning block: key channel
// indices, the per-key FSM state encoding and a counter-width helper.
package key_pkg;

  localparam int KEY_LEFT   = 0;
  localparam int KEY_RIGHT  = 1;
  localparam int KEY_ROTATE = 2;
  localparam int KEY_FALL   = 3;

  typedef enum logic [1:0] {
    KEY_RELEASED  = 2'd0,
    KEY_PRESSED   = 2'd1,
    KEY_REPEATING = 2'd2
  } key_state_e;

  // Bits needed to hold the values 0 .. n-1 (at least one bit).
  function automatic int cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_debounce_if.sv
// Key bundle between the board buttons and the game logic.
// master: drives the raw keys; slave: the debouncer.
interface key_debounce_if #(
  parameter int NUM_KEYS = 4
);
  import key_pkg::*;

  logic [NUM_KEYS-1:0] key_in;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_press;

  modport master (output key_in, input key_level, input key_press);
  modport slave  (input key_in, output key_level, output key_press);

endinterface

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, debounce counter, press FSM and,
// when KEY_AUTOREPEAT_EN is defined, the auto-repeat counter.
//
//  state          | meaning
//  ---------------+-----------------------------------------------------
//  KEY_RELEASED   | key released (debounced level 0)
//  KEY_PRESSED    | key held, waiting for the first repeat (or no repeat)
//  KEY_REPEATING  | key held, repeat pulses every REPEAT_PERIOD cycles
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int KEY_ACTIVE_LOW  = 1,
  parameter int DEBOUNCE_CYCLES = 660000,
  parameter int REPEAT_DELAY    = 13200000,
  parameter int REPEAT_PERIOD   = 3300000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  output logic level_o,
  output logic press_o
);

  localparam int            DW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DMAX     = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic          SYNC_RST = (KEY_ACTIVE_LOW != 0);

  localparam logic [1:0] S_RELEASED = KEY_RELEASED;
  localparam logic [1:0] S_PRESSED  = KEY_PRESSED;

  if (DEBOUNCE_CYCLES < 2 || REPEAT_PERIOD < 2 || REPEAT_DELAY < 1) begin : g_bad_param
    $error("key_debounce_ch: DEBOUNCE_CYCLES and REPEAT_PERIOD must be >= 2, REPEAT_DELAY >= 1");
  end

  logic [1:0]    sync_q;
  logic          s;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [1:0]    state_q, state_d;
  logic          accept;

  // Synchroniser flops sit at the released level out of reset so no
  // phantom press is seen while the pipeline refills.
  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= {2{SYNC_RST}};
    else        sync_q <= {sync_q[0], key_i};
  end

  assign s = sync_q[1] ^ SYNC_RST;

  // Debounce: count consecutive cycles where the input disagrees with the
  // accepted level; any agreeing cycle restarts the count.
  always_comb begin
    accept  = 1'b0;
    dcnt_d  = dcnt_q;
    level_d = level_q;
    if (s == level_q) begin
      dcnt_d = '0;
    end else if (dcnt_q >= DMAX) begin
      accept  = 1'b1;
      level_d = ~level_q;
      dcnt_d  = '0;
    end else begin
      dcnt_d = dcnt_q + DW'(1);
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int            RW      = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
  localparam logic [RW-1:0] RD_MAX  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_MAX  = RW'(REPEAT_PERIOD - 1);
  localparam logic [1:0]    S_REPEATING = KEY_REPEATING;

  logic [RW-1:0] rcnt_q, rcnt_d;

  // Press FSM with auto-repeat; an accepted release beats a repeat expiry.
  always_comb begin
    state_d = state_q;
    press_d = 1'b0;
    rcnt_d  = rcnt_q;
    case (state_q)
      S_RELEASED: begin
        if (accept && !level_q) begin
          state_d = S_PRESSED;
          press_d = 1'b1;
          rcnt_d  = '0;
        end
      end
      S_PRESSED: begin
        if (accept) begin
          state_d = S_RELEASED;
        end else if (rcnt_q >= RD_MAX) begin
          state_d = S_REPEATING;
          press_d = 1'b1;
          rcnt_d  = '0;
        end else begin
          rcnt_d = rcnt_q + RW'(1);
        end
      end
      S_REPEATING: begin
        if (accept) begin
          state_d = S_RELEASED;
        end else if (rcnt_q >= RP_MAX) begin
          press_d = 1'b1;
          rcnt_d  = '0;
        end else begin
          rcnt_d = rcnt_q + RW'(1);
        end
      end
      default: begin
        state_d = S_RELEASED;
        rcnt_d  = '0;
      end
    endcase
  end

  // Repeat counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) rcnt_q <= '0;
    else        rcnt_q <= rcnt_d;
  end
`else
  // Press FSM without auto-repeat: one pulse per accepted press.
  always_comb begin
    state_d = state_q;
    press_d = 1'b0;
    case (state_q)
      S_RELEASED: begin
        if (accept && !level_q) begin
          state_d = S_PRESSED;
          press_d = 1'b1;
        end
      end
      S_PRESSED: begin
        if (accept) state_d = S_RELEASED;
      end
      default: state_d = S_RELEASED;
    endcase
  end
`endif

  // Channel state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dcnt_q  <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      state_q <= S_RELEASED;
    end else begin
      dcnt_q  <= dcnt_d;
      level_q <= level_d;
      press_q <= press_d;
      state_q <= state_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/key_debounce.sv
// Push-button conditioning for the tetris core: NUM_KEYS independent
// channels of synchronise + debounce + press pulse.
// Build option: define KEY_AUTOREPEAT_EN to add hold-to-repeat pulses.
module key_debounce
  import key_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int KEY_ACTIVE_LOW  = 1,
  parameter int DEBOUNCE_CYCLES = 660000,
  parameter int REPEAT_DELAY    = 13200000,
  parameter int REPEAT_PERIOD   = 3300000
) (
  input logic              clk,
  input logic              rst_n,
  key_debounce_if.slave    bus
);

  logic [NUM_KEYS-1:0] level_w;
  logic [NUM_KEYS-1:0] press_w;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .key_i   (bus.key_in[i]),
      .level_o (level_w[i]),
      .press_o (press_w[i])
    );
  end

  assign bus.key_level = level_w;
  assign bus.key_press = press_w;

endmodule

// File: doc/key_debounce.md
# key_debounce

Conditions the four raw push-button inputs (left, right, rotate, fall) before they reach the game logic. It runs on the pixel clock next to the tetris core. Each key is synchronised, debounced and converted into a stable level and a single-cycle press pulse. The level drives the board LEDs; the pulse drives the game's move and rotate commands.

## Interface
Parameters:
- `NUM_KEYS`, default 4: number of key channels. Bit order: 0 left, 1 right, 2 rotate, 3 fall.
- `KEY_ACTIVE_LOW`, default 1: 1 means a raw input at 0 is "pressed".
- `DEBOUNCE_CYCLES`, default 660000: consecutive cycles a new level must persist before it is accepted. Minimum 2.
- `REPEAT_DELAY`, default 13200000: hold time from the accepted press to the first repeat pulse. Used only with auto-repeat.
- `REPEAT_PERIOD`, default 3300000: cycles between subsequent repeat pulses. Minimum 2. Used only with auto-repeat.

Ports:
- `clk`, input, 1: pixel clock; all logic is on its rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `key_in`, input, `NUM_KEYS`: raw asynchronous button inputs.
- `key_level`, output, `NUM_KEYS`: debounced level, 1 = pressed.
- `key_press`, output, `NUM_KEYS`: one-cycle pulse on an accepted press, and on each auto-repeat.

## Operation
- Per key, a 2-flop synchroniser. Its flops reset to the released level, i.e. 1 when `KEY_ACTIVE_LOW`=1.
- The input is normalised after synchronisation: `s = sync ^ KEY_ACTIVE_LOW`, so 1 = pressed.
- Per-key FSM has three states: RELEASED, PRESSED, REPEATING. RELEASED is the reset state.
- Debounce counter `dcnt`:
  - Increments each cycle that `s` differs from `key_level`.
  - Clears to 0 on any cycle where `s` equals `key_level`, so a bounce restarts the count.
  - When `dcnt` = `DEBOUNCE_CYCLES`-1 and `s` still differs, `key_level` toggles and `dcnt` clears.
- RELEASED → PRESSED on an accepted press. `key_press` pulses for 1 cycle and the repeat counter `rcnt` clears.
- PRESSED → RELEASED on an accepted release. No pulse is generated on release.
- Repeat counting (auto-repeat builds only):
  - In PRESSED, `rcnt` counts up. At `REPEAT_DELAY`-1, `key_press` pulses, the state moves to REPEATING and `rcnt` clears.
  - In REPEATING, a pulse fires every `REPEAT_PERIOD` cycles.
  - An accepted release returns to RELEASED from either state.
- Accepted release and repeat expiry in the same cycle: the release wins and no pulse is generated.
- Channels are fully independent. Simultaneous presses on several keys give simultaneous pulses.
- Counter widths are `$clog2` of the largest relevant parameter. Counters saturate and never wrap.

## Timing
- All outputs are registered.
- Reset value of every output is 0. All counters reset to 0 and every FSM to RELEASED.
- Press latency: the raw edge is sampled at edge E. `key_level` and `key_press` rise together at edge E+2+`DEBOUNCE_CYCLES`-1.
- Release latency: identical to press latency.
- `key_press` is high for exactly 1 cycle per event. It is never high on two consecutive cycles.
- First repeat pulse: `REPEAT_DELAY` cycles after the press pulse. Subsequent repeats are spaced `REPEAT_PERIOD` cycles apart.
- Reset asserted mid-press returns the channel to RELEASED with outputs at 0. A key still held after reset deasserts is re-debounced and produces a fresh press pulse after the full latency.

## Configuration
- `KEY_AUTOREPEAT_EN` defined:
  - The repeat counter and REPEATING state are compiled in.
  - Auto-repeat applies to every channel.
- `KEY_AUTOREPEAT_EN` undefined:
  - No repeat logic is built.
  - The FSM reduces to RELEASED and PRESSED.
  - `key_press` fires once per accepted press only.
  - `REPEAT_DELAY` and `REPEAT_PERIOD` are ignored.

## Structure
- Shared package `key_pkg` holds:
  - the key index constants `KEY_LEFT`=0, `KEY_RIGHT`=1, `KEY_ROTATE`=2, `KEY_FALL`=3;
  - the per-key FSM state enum.
- Sub-module `key_debounce_ch` covers one channel: synchroniser, debounce counter, FSM and repeat counter.
- The top module instantiates `NUM_KEYS` copies in a generate loop.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=8, `REPEAT_DELAY`=20, `REPEAT_PERIOD`=5, `KEY_ACTIVE_LOW`=1.
- Clean press: drive `key_in[0]` from 1 to 0 and hold. Expect `key_level[0]` and a 1-cycle `key_press[0]` exactly 9 edges after the first sampling edge; other bits stay 0.
- Bounce: toggle `key_in[1]` every 3 cycles for 40 cycles, then hold at 0. Expect no output during the toggling and exactly one pulse 9 edges after the final transition.
- Release: after a press, drive `key_in[2]` to 1. Expect `key_level[2]` to fall 9 edges later with no `key_press` pulse.
- Auto-repeat (`KEY_AUTOREPEAT_EN` defined): hold `key_in[3]` low for 60 cycles after acceptance. Expect pulses at +0, +20, +25, +30, …, +55. With the macro undefined, expect a single pulse at +0.
- Simultaneous keys: press all four keys on the same cycle. Expect `key_press`=4'b1111 for exactly one cycle.
- Mid-operation reset: pulse `rst_n` low for 1 cycle while a key is held pressed. Expect all outputs 0 next cycle, then a new press pulse 9 edges after `rst_n` returns high.
